top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_ram.sv | 40 ++++
 rtl/spi_slave.sv | 74 +++++++
 rtl/top.sv | 24 ++
 tb/tb_top.sv | 117 +++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and frame opcodes for the SPI RAM slice
package spi_pkg;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_ram.sv
// spi_ram: single-port RAM driven by decoded SPI frames (address/data/read opcodes)
module spi_ram
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
);
  logic [ADDR_SIZE-1:0] mem [0:MEM_DEPTH-1];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  // execute one opcode per rx_valid; storage is never cleared and reset blocks writes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (rx_data[9:8])
          OP_WR_ADDR: wr_addr <= ADDR_SIZE'(rx_data[7:0]);
          OP_WR_DATA: if (32'(wr_addr) < MEM_DEPTH) mem[wr_addr] <= ADDR_SIZE'(rx_data[7:0]);
          OP_RD_ADDR: rd_addr <= ADDR_SIZE'(rx_data[7:0]);
          default: begin
            tx_data  <= (32'(rd_addr) < MEM_DEPTH) ? 8'(mem[rd_addr]) : 8'h00;
            tx_valid <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: deserialises 10-bit MOSI frames and serialises read data onto MISO
module spi_slave
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_n,
  input  logic       mosi,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       miso,
  output logic [9:0] rx_data,
  output logic       rx_valid
);
  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [8:0] sh;
  logic       rd_flag;
  logic [7:0] tx_sh;
  logic [3:0] tx_cnt;
  // frame FSM, 10-bit receive shifter, and 8-bit transmit shifter in READ_DATA
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      sh       <= '0;
      rd_flag  <= 1'b0;
      tx_sh    <= '0;
      tx_cnt   <= '0;
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n) begin
        state   <= IDLE;
        bit_cnt <= '0;
        tx_cnt  <= '0;
        miso    <= 1'b0;
      end else begin
        case (state)
          IDLE:    state <= CHK_CMD;
          CHK_CMD: state <= !mosi ? WRITE : rd_flag ? READ_DATA : READ_ADD;
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt < 4'd10) begin
              sh      <= {sh[7:0], mosi};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) begin
                rx_data  <= {sh, mosi};
                rx_valid <= 1'b1;
                if (sh[8:7] == OP_RD_ADDR) rd_flag <= 1'b1;
              end
            end else if (state == READ_DATA) begin
              if (tx_cnt == 4'd0 && tx_valid) begin
                miso   <= tx_data[7];
                tx_sh  <= {tx_data[6:0], 1'b0};
                tx_cnt <= 4'd1;
              end else if (tx_cnt == 4'd8) begin
                miso    <= 1'b0;
                tx_cnt  <= 4'd0;
                rd_flag <= 1'b0;
              end else if (tx_cnt != 4'd0) begin
                miso   <= tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
                tx_cnt <= tx_cnt + 4'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/top.sv
// top: SPI slave front end wired to its backing RAM
module top #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  spi_slave slave (
    .clk(clk), .rst(rst_n), .ss_n(SS_n), .mosi(MOSI), .tx_data(tx_data),
    .tx_valid(tx_valid), .miso(MISO), .rx_data(rx_data), .rx_valid(rx_valid)
  );
  spi_ram #(.ADDR_SIZE(ADDR_SIZE), .MEM_DEPTH(MEM_DEPTH)) ram (
    .clk(clk), .rst(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid)
  );
endmodule

// File: tb/tb_top.sv
// tb_top: directed SPI frames with a scoreboard of expected MISO read bytes
module tb_top;
  import spi_pkg::*;
  logic clk, rst_n, SS_n, MOSI, MISO;
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  top dut (.clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask
  task automatic frame(input logic cmd, input logic [9:0] f, input int n, input int hold);
    @(negedge clk); SS_n = 0; MOSI = 0;
    @(negedge clk); MOSI = cmd;
    for (int i = 9; i > 9 - n; i--) begin
      @(negedge clk); MOSI = f[i];
    end
    repeat (hold) @(negedge clk);
    SS_n = 1; MOSI = 0;
    @(negedge clk);
  endtask
  initial begin
    logic [7:0] got, e;
    forever begin
      @(negedge clk);
      if (dut.tx_valid) begin
        for (int i = 7; i >= 0; i--) begin
          @(negedge clk); got[i] = MISO;
        end
        if (exp_q.size() == 0) chk("rd_unexpected", 32'(got), 32'hdead);
        else begin
          e = exp_q.pop_front();
          chk("miso_byte", 32'(got), 32'(e));
        end
        @(negedge clk);
        chk("miso_idle", 32'(MISO), 0);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    clk = 0; rst_n = 1; SS_n = 1; MOSI = 0;
    dut.ram.mem[8'h00] = 8'hFF;
    dut.ram.mem[8'h10] = 8'h77;
    dut.ram.mem[8'h20] = 8'h11;
    dut.ram.mem[8'hA5] = 8'h00;
    dut.ram.mem[8'hFF] = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 0;
    chk("rst_miso", 32'(MISO), 0);
    chk("rst_state", 32'(dut.slave.state), 32'(IDLE));
    chk("rst_wr_addr", 32'(dut.ram.wr_addr), 0);
    chk("rst_mem_keep", 32'(dut.ram.mem[8'h10]), 32'h77);
    exp_q.push_back(8'h00);
    frame(1, {OP_RD_DATA, 8'h00}, 10, 12);
    chk("noflag_flag", 32'(dut.slave.rd_flag), 0);
    frame(0, {OP_WR_ADDR, 8'hA5}, 10, 2);
    chk("wr_addr_a5", 32'(dut.ram.wr_addr), 32'hA5);
    frame(0, {OP_WR_DATA, 8'h3C}, 10, 1);
    chk("mem_a5", 32'(dut.ram.mem[8'hA5]), 32'h3C);
    frame(1, {OP_RD_ADDR, 8'hA5}, 10, 2);
    chk("rd_addr_a5", 32'(dut.ram.rd_addr), 32'hA5);
    chk("flag_set", 32'(dut.slave.rd_flag), 1);
    exp_q.push_back(8'h3C);
    frame(1, {OP_RD_DATA, 8'h5A}, 10, 12);
    chk("flag_clear", 32'(dut.slave.rd_flag), 0);
    frame(0, {OP_WR_ADDR, 8'h20}, 10, 2);
    chk("wr_addr_20", 32'(dut.ram.wr_addr), 32'h20);
    frame(0, {OP_WR_DATA, 8'hAB}, 5, 1);
    chk("abort_state", 32'(dut.slave.state), 32'(IDLE));
    chk("abort_cnt", 32'(dut.slave.bit_cnt), 0);
    repeat (3) @(negedge clk);
    chk("abort_nowrite", 32'(dut.ram.mem[8'h20]), 32'h11);
    frame(0, {OP_WR_DATA, 8'hC3}, 10, 1);
    chk("post_abort_wr", 32'(dut.ram.mem[8'h20]), 32'hC3);
    frame(1, {OP_RD_ADDR, 8'h20}, 10, 2);
    exp_q.push_back(8'hC3);
    frame(1, {OP_RD_DATA, 8'h00}, 10, 12);
    frame(1, {OP_RD_ADDR, 8'h10}, 10, 2);
    exp_q.push_back(8'h77);
    frame(1, {OP_RD_DATA, 8'hFF}, 10, 12);
    frame(0, {OP_WR_ADDR, 8'hFF}, 10, 2);
    frame(0, {OP_WR_DATA, 8'h81}, 10, 2);
    chk("mem_ff", 32'(dut.ram.mem[8'hFF]), 32'h81);
    frame(1, {OP_RD_ADDR, 8'hFF}, 10, 2);
    exp_q.push_back(8'h81);
    frame(1, {OP_RD_DATA, 8'h00}, 10, 12);
    frame(1, {OP_RD_ADDR, 8'h00}, 10, 2);
    exp_q.push_back(8'hFF);
    frame(1, {OP_RD_DATA, 8'h00}, 10, 12);
    @(negedge clk); SS_n = 0; MOSI = 0;
    @(negedge clk); MOSI = 0;
    for (int i = 9; i > 0; i--) begin
      @(negedge clk); MOSI = (10'({OP_WR_DATA, 8'hEE}) >> i) & 10'd1;
    end
    @(negedge clk); MOSI = 0; rst_n = 1;
    repeat (2) @(negedge clk);
    rst_n = 0; SS_n = 1;
    repeat (3) @(negedge clk);
    chk("midrst_mem", 32'(dut.ram.mem[8'hFF]), 32'h81);
    chk("midrst_wr_addr", 32'(dut.ram.wr_addr), 0);
    chk("midrst_state", 32'(dut.slave.state), 32'(IDLE));
    chk("midrst_miso", 32'(MISO), 0);
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
